prr_stream_port: RTL

PRR_STREAM_PORT -- requirements
Module: prr_stream_port

---
 rtl/prr_stream_port.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/prr_stream_port.sv
// prr_stream_port: per-channel GLB-to-PRR stream port (OFF/VALID/READY_VALID/STATIC ingress, FWFT FIFO).
// Define PRR_STREAM_OVERFLOW_CHK_EN to build the sticky per-channel overflow flags.
module prr_stream_port #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 4,
    parameter int ALMOST_DIFF = 1,
    parameter int CNT_W       = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        stall,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        strm_start,
    input  logic                     cfg_wr_en,
    input  logic [CH_W-1:0]          cfg_wr_ch,
    input  logic [2:0]               cfg_wr_addr,
    input  logic [CNT_W-1:0]         cfg_wr_data,
    input  logic [CH_W-1:0]          cfg_rd_ch,
    input  logic [2:0]               cfg_rd_addr,
    output logic [CNT_W-1:0]         cfg_rd_data,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_vld,
    output logic [NUM_CH-1:0]        in_rdy,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_vld,
    input  logic [NUM_CH-1:0]        out_rdy,
    output logic [NUM_CH-1:0]        sched_done,
    output logic [NUM_CH-1:0]        ovf_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] RDY_LIM = CW'(DEPTH - ALMOST_DIFF);
    localparam logic [1:0] M_VALID  = 2'd1;
    localparam logic [1:0] M_RV     = 2'd2;
    localparam logic [1:0] M_STATIC = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [CNT_W-1:0] rdWord [NUM_CH];

    assign cfg_rd_data = rdWord[cfg_rd_ch];

    for (genvar g = 0; g < NUM_CH; g++) begin : gCh
        logic [1:0]        mode_q;
        logic [CNT_W-1:0]  ext0_q, ext1_q, str0_q, str1_q;
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PW-1:0]     wrPtr_q, rdPtr_q;
        logic [CW-1:0]     count_q;
        logic              inRdy_q, done_q;
        state_t            state_q;
        logic [CNT_W-1:0]  cyc_q, target_q, i0_q, i1_q, base1_q;
        logic [CNT_W-1:0]  lastI0, lastI1, rdLocal;
        logic [DATA_W-1:0] inWord;
        logic              cfgSel, schedHit, pushReq, pushOk, pop, full;

        assign inWord   = in_data[g*DATA_W +: DATA_W];
        assign cfgSel   = cfg_wr_en && (cfg_wr_ch == CH_W'(g));
        assign lastI0   = (ext0_q == '0) ? '0 : ext0_q - CNT_W'(1);
        assign lastI1   = (ext1_q == '0) ? '0 : ext1_q - CNT_W'(1);
        assign schedHit = (state_q == S_RUN) && !stall[g] && (cyc_q == target_q);
        assign full     = (count_q == FULL_C);
        assign pop      = (count_q != '0) && out_rdy[g];
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        assign pushOk   = pushReq && (!full || pop);

        always_comb begin
            pushReq = 1'b0;
            case (mode_q)
                M_VALID:  pushReq = in_vld[g] && !stall[g];
                M_RV:     pushReq = in_vld[g] && !stall[g] && (count_q < FULL_C);
                M_STATIC: pushReq = schedHit;
                default:  pushReq = 1'b0;
            endcase
        end

        always_comb begin
            rdLocal = '0;
            case (cfg_rd_addr)
                3'd0:    rdLocal = CNT_W'(mode_q);
                3'd1:    rdLocal = ext0_q;
                3'd2:    rdLocal = ext1_q;
                3'd3:    rdLocal = str0_q;
                3'd4:    rdLocal = str1_q;
                default: rdLocal = '0;
            endcase
        end
        assign rdWord[g] = rdLocal;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mode_q <= '0;
                ext0_q <= '0;
                ext1_q <= '0;
                str0_q <= '0;
                str1_q <= '0;
            end else if (cfgSel) begin
                case (cfg_wr_addr)
                    3'd0:    mode_q <= cfg_wr_data[1:0];
                    3'd1:    ext0_q <= cfg_wr_data;
                    3'd2:    ext1_q <= cfg_wr_data;
                    3'd3:    str0_q <= cfg_wr_data;
                    3'd4:    str1_q <= cfg_wr_data;
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (pushOk && !flush) mem_q[wrPtr_q] <= inWord;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                count_q <= '0;
                inRdy_q <= 1'b0;
            end else begin
                inRdy_q <= (mode_q == M_RV) && !stall[g] && (count_q < RDY_LIM);
                if (flush) begin
                    wrPtr_q <= '0;
                    rdPtr_q <= '0;
                    count_q <= '0;
                end else begin
                    if (pushOk) wrPtr_q <= wrPtr_q + PW'(1);
                    if (pop)    rdPtr_q <= rdPtr_q + PW'(1);
                    count_q <= count_q + CW'(pushOk) - CW'(pop);
                end
            end
        end

        // Static schedule: inner index i0 walks stride0 from base1, outer index i1 moves base1 by stride1.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= S_IDLE;
                cyc_q    <= '0;
                target_q <= '0;
                i0_q     <= '0;
                i1_q     <= '0;
                base1_q  <= '0;
                done_q   <= 1'b0;
            end else if (flush) begin
                state_q <= S_IDLE;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (strm_start[g] && (mode_q == M_STATIC)) begin
                            state_q  <= S_RUN;
                            cyc_q    <= '0;
                            target_q <= '0;
                            i0_q     <= '0;
                            i1_q     <= '0;
                            base1_q  <= '0;
                            done_q   <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (!stall[g]) begin
                            cyc_q <= cyc_q + CNT_W'(1);
                            if (cyc_q == target_q) begin
                                if (i0_q == lastI0) begin
                                    i0_q <= '0;
                                    if (i1_q == lastI1) begin
                                        state_q <= S_DONE;
                                        done_q  <= 1'b1;
                                    end else begin
                                        i1_q     <= i1_q + CNT_W'(1);
                                        base1_q  <= base1_q + str1_q;
                                        target_q <= base1_q + str1_q;
                                    end
                                end else begin
                                    i0_q     <= i0_q + CNT_W'(1);
                                    target_q <= target_q + str0_q;
                                end
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end

`ifdef PRR_STREAM_OVERFLOW_CHK_EN
        logic drop, ovf_q;
        assign drop = pushReq && full && !pop;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)   ovf_q <= 1'b0;
            else if (flush) ovf_q <= 1'b0;
            else if (drop)  ovf_q <= 1'b1;
        end
        assign ovf_err[g] = ovf_q;
`else
        assign ovf_err[g] = 1'b0;
`endif

        assign in_rdy[g]                    = inRdy_q;
        assign out_vld[g]                   = (count_q != '0);
        assign out_data[g*DATA_W +: DATA_W] = mem_q[rdPtr_q];
        assign sched_done[g]                = done_q;
    end

endmodule
